// File: rtl/cache_mux_types.sv
// Shared type definitions for the cache-side multiplexers and the L2 arbiter.
package cache_mux_types;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arbiter_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              read;
        logic              write;
        logic [LINE_W-1:0] wdata;
    } l2_req_t;

    localparam l2_req_t L2_REQ_RESET = '{addr: 32'h0, read: 1'b0, write: 1'b0, wdata: 256'h0};

endpackage

// File: rtl/l2_arbiter.sv
// Two-port L1I/L1D arbiter in front of the unified L2; one outstanding L2 transaction at a time.
// Optional macro ROUND_ROBIN_EN: alternate between ports on ties instead of always favouring D.
module l2_arbiter
    import cache_mux_types::*;
(
    input  logic         clk,
    input  logic         rst,

    input  logic [31:0]  i_mem_address,
    input  logic         i_mem_read,
    output logic [255:0] i_mem_rdata256,
    output logic         i_mem_resp,

    input  logic [31:0]  d_mem_address,
    input  logic         d_mem_read,
    input  logic         d_mem_write,
    input  logic [255:0] d_mem_wdata256,
    output logic [255:0] d_mem_rdata256,
    output logic         d_mem_resp,

    output logic [31:0]  l2_mem_address,
    output logic         l2_mem_read,
    output logic         l2_mem_write,
    output logic [255:0] l2_mem_wdata256,
    input  logic [255:0] l2_mem_rdata256,
    input  logic         l2_mem_resp
);

    arbiter_state_t state_q, state_d;
    l2_req_t        req_q, req_d;

    logic i_req_s;
    logic d_req_s;
    logic grant_i_s;
    logic grant_d_s;

    assign i_req_s = i_mem_read;
    assign d_req_s = d_mem_read | d_mem_write;

`ifdef ROUND_ROBIN_EN
    // High when D won the most recent grant; reset value favours D on the first tie.
    logic last_d_q, last_d_d;

    // Tie resolution: the port that did not win last time gets the grant.
    always_comb begin
        if (d_req_s && (!i_req_s || !last_d_q)) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Pointer only moves when a grant is actually issued.
    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE) begin
            if (grant_d_s) begin
                last_d_d = 1'b1;
            end else if (i_req_s) begin
                last_d_d = 1'b0;
            end else begin
                last_d_d = last_d_q;
            end
        end else begin
            last_d_d = last_d_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    // Fixed priority: D always wins a tie.
    always_comb begin
        if (d_req_s) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
    end
`endif

    assign grant_i_s = i_req_s & ~grant_d_s;

    // Next-state and request-register capture.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (grant_d_s) begin
                    // A simultaneous read and write-back from D is treated as the write-back.
                    state_d       = SERVE_D;
                    req_d.addr    = d_mem_address;
                    req_d.write   = d_mem_write;
                    req_d.read    = d_mem_read & ~d_mem_write;
                    req_d.wdata   = d_mem_wdata256;
                end else if (grant_i_s) begin
                    state_d       = SERVE_I;
                    req_d.addr    = i_mem_address;
                    req_d.read    = 1'b1;
                    req_d.write   = 1'b0;
                    req_d.wdata   = 256'h0;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_mem_resp) begin
                    state_d     = IDLE;
                    req_d.read  = 1'b0;
                    req_d.write = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = L2_REQ_RESET;
            end
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= L2_REQ_RESET;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    assign l2_mem_address  = req_q.addr;
    assign l2_mem_read     = req_q.read;
    assign l2_mem_write    = req_q.write;
    assign l2_mem_wdata256 = req_q.wdata;

    // Response routing is combinational so the L1 sees completion in the L2's response cycle.
    assign i_mem_resp     = (state_q == SERVE_I) & l2_mem_resp;
    assign d_mem_resp     = (state_q == SERVE_D) & l2_mem_resp;
    assign i_mem_rdata256 = l2_mem_rdata256;
    assign d_mem_rdata256 = l2_mem_rdata256;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: transaction-level model plus directed scenarios.
module tb_l2_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_mem_address;
    logic         i_mem_read;
    logic [255:0] i_mem_rdata256;
    logic         i_mem_resp;
    logic [31:0]  d_mem_address;
    logic         d_mem_read;
    logic         d_mem_write;
    logic [255:0] d_mem_wdata256;
    logic [255:0] d_mem_rdata256;
    logic         d_mem_resp;
    logic [31:0]  l2_mem_address;
    logic         l2_mem_read;
    logic         l2_mem_write;
    logic [255:0] l2_mem_wdata256;
    logic [255:0] l2_mem_rdata256;
    logic         l2_mem_resp;

    int checks   = 0;
    int failures = 0;

    l2_arbiter dut (
        .clk(clk), .rst(rst),
        .i_mem_address(i_mem_address), .i_mem_read(i_mem_read),
        .i_mem_rdata256(i_mem_rdata256), .i_mem_resp(i_mem_resp),
        .d_mem_address(d_mem_address), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_wdata256(d_mem_wdata256), .d_mem_rdata256(d_mem_rdata256), .d_mem_resp(d_mem_resp),
        .l2_mem_address(l2_mem_address), .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
        .l2_mem_wdata256(l2_mem_wdata256), .l2_mem_rdata256(l2_mem_rdata256), .l2_mem_resp(l2_mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: who owns the L2, what was sent, who won last.
    int           m_owner;   // 0 none, 1 I, 2 D
    int           m_last;    // 1 I, 2 D
    logic [31:0]  m_addr;
    logic         m_rd, m_wr;
    logic [255:0] m_wdata;
    bit           started = 1'b0;

    function automatic int pick_winner(input logic ir, input logic dr, input int last);
        if (ir && dr) begin
`ifdef ROUND_ROBIN_EN
            return (last == 2) ? 1 : 2;
`else
            return 2;
`endif
        end
        if (dr) return 2;
        if (ir) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        int w;
        started <= 1'b1;
        w = pick_winner(i_mem_read, d_mem_read | d_mem_write, m_last);
        if (rst) begin
            m_owner <= 0; m_last <= 1; m_addr <= 32'h0;
            m_rd <= 1'b0; m_wr <= 1'b0; m_wdata <= 256'h0;
        end else if (m_owner != 0) begin
            if (l2_mem_resp) begin
                m_owner <= 0; m_rd <= 1'b0; m_wr <= 1'b0;
            end
        end else if (w == 1) begin
            m_owner <= 1; m_last <= 1; m_addr <= i_mem_address;
            m_rd <= 1'b1; m_wr <= 1'b0; m_wdata <= 256'h0;
        end else if (w == 2) begin
            m_owner <= 2; m_last <= 2; m_addr <= d_mem_address;
            m_rd <= ~d_mem_write; m_wr <= d_mem_write; m_wdata <= d_mem_wdata256;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("l2_addr",  {224'h0, l2_mem_address}, {224'h0, m_addr});
            chk("l2_read",  {255'h0, l2_mem_read},    {255'h0, m_rd});
            chk("l2_write", {255'h0, l2_mem_write},   {255'h0, m_wr});
            chk("l2_wdata", l2_mem_wdata256, m_wdata);
            chk("i_resp", {255'h0, i_mem_resp}, {255'h0, (m_owner == 1) && l2_mem_resp});
            chk("d_resp", {255'h0, d_mem_resp}, {255'h0, (m_owner == 2) && l2_mem_resp});
            chk("i_rdata", i_mem_rdata256, l2_mem_rdata256);
            chk("d_rdata", d_mem_rdata256, l2_mem_rdata256);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as the L2: wait for a request, respond after lat cycles, report which L1 got resp.
    task automatic serve(input int lat, input logic [255:0] line, output int got);
        int k;
        k = 0;
        while (!(l2_mem_read || l2_mem_write) && k < 20) begin
            tick();
            k++;
        end
        chk("grant_timeout", {255'h0, (k < 20)}, 256'h1);
        repeat (lat - 1) tick();
        l2_mem_resp     = 1'b1;
        l2_mem_rdata256 = line;
        @(negedge clk);
        got = i_mem_resp ? 1 : (d_mem_resp ? 2 : 0);
        chk("resp_onehot", {255'h0, (i_mem_resp & d_mem_resp)}, 256'h0);
        tick();
        l2_mem_resp = 1'b0;
    endtask

    logic [255:0] line_a5;
    logic [255:0] line_wd;
    int got1, got2, got3, exp2;

    initial begin
        line_a5 = {32{8'hA5}};
        line_wd = {8{32'h12345678}};
        rst = 1'b1;
        i_mem_address = 32'h0; i_mem_read = 1'b0;
        d_mem_address = 32'h0; d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_wdata256 = 256'h0;
        l2_mem_rdata256 = 256'h0; l2_mem_resp = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and quiet idle.
        repeat (5) tick();
        chk("rst_l2_read",  {255'h0, l2_mem_read},  256'h0);
        chk("rst_l2_write", {255'h0, l2_mem_write}, 256'h0);
        chk("rst_l2_addr",  {224'h0, l2_mem_address}, 256'h0);
        chk("rst_l2_wdata", l2_mem_wdata256, 256'h0);

        // I-cache read, 3-cycle L2.
        i_mem_address = 32'h0000_1000; i_mem_read = 1'b1;
        tick();
        chk("i_grant_read", {255'h0, l2_mem_read}, 256'h1);
        chk("i_grant_addr", {224'h0, l2_mem_address}, 256'h1000);
        serve(3, line_a5, got1);
        i_mem_read = 1'b0;
        chk("i_served", got1, 256'd1);
        @(negedge clk);
        chk("i_done_read", {255'h0, l2_mem_read}, 256'h0);
        tick();

        // D write-back with read also high: write wins.
        d_mem_address = 32'h0000_2020; d_mem_write = 1'b1; d_mem_read = 1'b1; d_mem_wdata256 = line_wd;
        tick();
        chk("d_wr_write", {255'h0, l2_mem_write}, 256'h1);
        chk("d_wr_read",  {255'h0, l2_mem_read},  256'h0);
        chk("d_wr_wdata", l2_mem_wdata256, line_wd);
        chk("d_wr_addr",  {224'h0, l2_mem_address}, 256'h2020);
        serve(2, 256'h0, got1);
        d_mem_write = 1'b0; d_mem_read = 1'b0;
        chk("d_served", got1, 256'd2);
        tick();

        // Two ties in succession; D keeps requesting so the second tie is real.
        i_mem_address = 32'h0000_0100; i_mem_read = 1'b1;
        d_mem_address = 32'h0000_0200; d_mem_read = 1'b1;
        serve(2, 256'h11, got1);
        chk("tie1_winner", got1, 256'd2);
        serve(2, 256'h22, got2);
`ifdef ROUND_ROBIN_EN
        exp2 = 1;
`else
        exp2 = 2;
`endif
        chk("tie2_winner", got2, exp2);
        if (got2 == 1) i_mem_read = 1'b0;
        else d_mem_read = 1'b0;
        serve(2, 256'h33, got3);
        chk("tie_last", got3, (exp2 == 1) ? 256'd2 : 256'd1);
        i_mem_read = 1'b0; d_mem_read = 1'b0;
        tick();

        // Reset while serving D: transaction abandoned, no resp.
        d_mem_address = 32'h0000_0300; d_mem_read = 1'b1;
        tick();
        chk("rst_mid_grant", {255'h0, l2_mem_read}, 256'h1);
        tick();
        rst = 1'b1; d_mem_read = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_read", {255'h0, l2_mem_read}, 256'h0);
        chk("rst_mid_addr", {224'h0, l2_mem_address}, 256'h0);
        chk("rst_mid_dresp", {255'h0, d_mem_resp}, 256'h0);
        tick();

        // Spurious L2 resp while idle.
        l2_mem_resp = 1'b1; l2_mem_rdata256 = line_a5;
        @(negedge clk);
        chk("spur_iresp", {255'h0, i_mem_resp}, 256'h0);
        chk("spur_dresp", {255'h0, d_mem_resp}, 256'h0);
        tick();
        l2_mem_resp = 1'b0;
        @(negedge clk);
        chk("spur_read", {255'h0, l2_mem_read}, 256'h0);
        tick();

        // Still idle and functional afterwards.
        i_mem_address = 32'h0000_0400; i_mem_read = 1'b1;
        serve(1, line_a5, got1);
        i_mem_read = 1'b0;
        chk("post_spur_i", got1, 256'd1);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
